// File: rtl/loba_seq_mult_pkg.sv
// Shared definitions for the LOBA sequential approximate multiplier:
// FSM state encoding, request mode encoding, term-count table, the
// split-window payload struct and the shift-sum generator (SSG).
package loba_seq_mult_pkg;

    localparam int unsigned N_W   = 16;  // operand width
    localparam int unsigned WIN_W = 8;   // width of each LOBA window
    localparam int unsigned K_W   = 4;   // width of a window shift amount
    localparam int unsigned SH_W  = 5;   // width of a summed shift amount
    localparam int unsigned P_W   = 32;  // product / accumulator width
    localparam int unsigned CNT_W = 2;   // term counter width

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SPLIT = 2'd1,
        ST_MUL   = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        MODE_T1  = 2'd0,
        MODE_T2  = 2'd1,
        MODE_T4  = 2'd2,
        MODE_T2R = 2'd3
    } mode_e;

    // One operand after splitting: high window/shift and low window/shift.
    typedef struct packed {
        logic [WIN_W-1:0] hi;
        logic [K_W-1:0]   kh;
        logic [WIN_W-1:0] lo;
        logic [K_W-1:0]   kl;
    } split_t;

    // Number of partial-product terms issued for each mode.
    function automatic logic [2:0] term_count(input mode_e m);
        logic [2:0] t;
        case (m)
            MODE_T1:  t = 3'd1;
            MODE_T2:  t = 3'd2;
            MODE_T4:  t = 3'd4;
            default:  t = 3'd2;
        endcase
        return t;
    endfunction

    // Shift-sum generator: 5-bit sum of two 4-bit window shifts.
    function automatic logic [SH_W-1:0] ssg(input logic [K_W-1:0] ka,
                                            input logic [K_W-1:0] kb);
        return SH_W'(ka) + SH_W'(kb);
    endfunction

endpackage

// File: rtl/loba_split.sv
// LOBA_SPLIT: splits an unsigned operand into two leading-one windows.
// The high window is the WIN_W bits starting at the leading one (kh is its
// shift); the low window is taken the same way from the remaining bits.
// A zero operand yields zero windows and zero shifts.
// Ports: x_i operand in; split_o {hi, kh, lo, kl} out (combinational).
module loba_split
    import loba_seq_mult_pkg::*;
(
    input  logic [N_W-1:0] x_i,
    output split_t         split_o
);

    // Shift that aligns the leading one to the top bit of a WIN_W window.
    function automatic logic [K_W-1:0] win_shift(input logic [N_W-1:0] x);
        logic [K_W-1:0] pos;
        pos = '0;
        for (int i = 0; i < int'(N_W); i++) begin
            if (x[i]) pos = K_W'(i);
        end
        return (pos > K_W'(WIN_W - 1)) ? (pos - K_W'(WIN_W - 1)) : '0;
    endfunction

    logic [K_W-1:0] kh;
    logic [K_W-1:0] kl;
    logic [N_W-1:0] mask;
    logic [N_W-1:0] resid;

    always_comb begin
        kh    = win_shift(x_i);
        mask  = (N_W'(1) << kh) - N_W'(1);
        resid = x_i & mask;
        kl    = win_shift(resid);

        split_o.hi = WIN_W'(x_i >> kh);
        split_o.kh = kh;
        split_o.lo = WIN_W'(resid >> kl);
        split_o.kl = kl;
    end

endmodule

// File: rtl/loba_term_acc.sv
// Term mux, shared 16x16 multiplier and 32-bit wrapping accumulator.
// sel_i picks the window pair: 0 hi*hi, 1 hi*lo, 2 lo*hi, 3 lo*lo.
// Ports: clk, rst_n; clr_i zeroes the accumulator; en_i adds the selected
// shifted term; a_i/b_i split operands; sum_c_o = accumulator + term (comb).
module loba_term_acc
    import loba_seq_mult_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [CNT_W-1:0] sel_i,
    input  split_t           a_i,
    input  split_t           b_i,
    output logic [P_W-1:0]   sum_c_o
);

    logic [N_W-1:0]  mul_x;
    logic [N_W-1:0]  mul_y;
    logic [SH_W-1:0] sh;
    logic [P_W-1:0]  prod;
    logic [P_W-1:0]  term;
    logic [P_W-1:0]  acc_q;
    logic [P_W-1:0]  acc_d;

    // Term select feeding the single multiplier.
    always_comb begin
        mul_x = N_W'(a_i.hi);
        mul_y = N_W'(b_i.hi);
        sh    = ssg(a_i.kh, b_i.kh);
        case (sel_i)
            2'd1: begin
                mul_y = N_W'(b_i.lo);
                sh    = ssg(a_i.kh, b_i.kl);
            end
            2'd2: begin
                mul_x = N_W'(a_i.lo);
                sh    = ssg(a_i.kl, b_i.kh);
            end
            2'd3: begin
                mul_x = N_W'(a_i.lo);
                mul_y = N_W'(b_i.lo);
                sh    = ssg(a_i.kl, b_i.kl);
            end
            default: ;
        endcase
    end

    // Shifted term is truncated to P_W; the sum wraps modulo 2^P_W.
    always_comb begin
        prod    = P_W'(mul_x) * P_W'(mul_y);
        term    = prod << sh;
        sum_c_o = acc_q + term;
        acc_d   = acc_q;
        if (clr_i)     acc_d = '0;
        else if (en_i) acc_d = sum_c_o;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) acc_q <= '0;
        else        acc_q <= acc_d;
    end

endmodule

// File: rtl/loba_seq_mult.sv
// LOBA sequential approximate multiplier. Each operand is split into two
// leading-one windows; 1, 2 or 4 window products are issued one per cycle
// through a shared multiplier and accumulated into P.
// Ports: clk, rst_n (async, active low); in_valid/in_ready request
// handshake with A, B, mode; out_valid/out_ready result handshake with P;
// busy high whenever the FSM is not idle.
module loba_seq_mult
    import loba_seq_mult_pkg::*;
#(
    parameter int unsigned N = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [1:0]     mode,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] P,
    output logic           busy
);

    state_e           state_q,   state_d;
    logic [N-1:0]     a_q,       a_d;
    logic [N-1:0]     b_q,       b_d;
    mode_e            mode_q,    mode_d;
    split_t           split_a_q, split_a_d;
    split_t           split_b_q, split_b_d;
    logic [CNT_W-1:0] cnt_q,     cnt_d;
    logic [2*N-1:0]   p_q,       p_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q,     busy_d;
    logic             out_valid_q, out_valid_d;

    split_t           split_a_c;
    split_t           split_b_c;
    logic             acc_clr;
    logic             acc_en;
    logic [P_W-1:0]   sum_c;
    logic [CNT_W-1:0] last_c;

    loba_split u_split_a (
        .x_i     (a_q),
        .split_o (split_a_c)
    );

    loba_split u_split_b (
        .x_i     (b_q),
        .split_o (split_b_c)
    );

    loba_term_acc u_term_acc (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (acc_clr),
        .en_i    (acc_en),
        .sel_i   (cnt_q),
        .a_i     (split_a_q),
        .b_i     (split_b_q),
        .sum_c_o (sum_c)
    );

    // Index of the final term for the captured mode.
    assign last_c = CNT_W'(term_count(mode_q) - 3'd1);

    // Next-state and datapath control.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d    = mode_q;
        split_a_d = split_a_q;
        split_b_d = split_b_q;
        cnt_d     = cnt_q;
        p_d       = p_q;
        acc_clr   = 1'b0;
        acc_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    mode_d  = mode_e'(mode);
                    state_d = ST_SPLIT;
                end
            end
            ST_SPLIT: begin
                split_a_d = split_a_c;
                split_b_d = split_b_c;
                cnt_d     = '0;
                acc_clr   = 1'b1;
                state_d   = ST_MUL;
            end
            ST_MUL: begin
                acc_en = 1'b1;
                cnt_d  = cnt_q + CNT_W'(1);
                if (cnt_q == last_c) begin
                    p_d     = (2*N)'(sum_c);
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        in_ready_d  = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        out_valid_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            mode_q      <= MODE_T1;
            split_a_q   <= '0;
            split_b_q   <= '0;
            cnt_q       <= '0;
            p_q         <= '0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            mode_q      <= mode_d;
            split_a_q   <= split_a_d;
            split_b_q   <= split_b_d;
            cnt_q       <= cnt_d;
            p_q         <= p_d;
            in_ready_q  <= in_ready_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign out_valid = out_valid_q;
    assign P         = p_q;

endmodule

// File: tb/tb_loba_seq_mult.sv
// Self-checking bench for loba_seq_mult. Expected products come from an
// independent model of the two-window leading-one split and are queued when
// a request is driven, then popped when the DUT presents a result.
module tb_loba_seq_mult;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] A;
    logic [15:0] B;
    logic [1:0]  mode;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] P;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];

    loba_seq_mult #(.N(16)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .mode      (mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .P         (P),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Smallest right shift that brings x below 256 gives the window.
    function automatic void model_win(input logic [15:0] x,
                                      output logic [15:0] w, output int k);
        k = 0;
        while ((x >> k) >= 16'd256) k++;
        w = x >> k;
    endfunction

    function automatic logic [31:0] model(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic [1:0]  m);
        logic [15:0] ah, al, bh, bl, ra, rb;
        int          kha, kla, khb, klb, nt;
        logic [63:0] t[4];
        logic [31:0] s;
        model_win(a, ah, kha);
        ra = a - 16'(ah << kha);
        model_win(ra, al, kla);
        model_win(b, bh, khb);
        rb = b - 16'(bh << khb);
        model_win(rb, bl, klb);
        t[0] = (64'(ah) * 64'(bh)) << (kha + khb);
        t[1] = (64'(ah) * 64'(bl)) << (kha + klb);
        t[2] = (64'(al) * 64'(bh)) << (kla + khb);
        t[3] = (64'(al) * 64'(bl)) << (kla + klb);
        nt = (m == 2'd0) ? 1 : ((m == 2'd2) ? 4 : 2);
        s = 32'd0;
        for (int i = 0; i < nt; i++) s = s + t[i][31:0];
        return s;
    endfunction

    // Drive one request at a negedge with the DUT idle; returns the number of
    // cycles from the accept cycle to the first cycle showing out_valid
    // (40 means out_valid never came).
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [1:0] m, output int lat);
        A = a; B = b; mode = m; in_valid = 1'b1;
        exp_q.push_back(model(a, b, m));
        @(negedge clk);
        in_valid = 1'b0;
        A = 16'($urandom); B = 16'($urandom); mode = 2'($urandom);
        lat = 1;
        while (!out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; mode = '0;
        repeat (3) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (P !== 32'd0) begin errors++; $display("FAIL reset_P got=%h exp=0", P); end
    endtask

    // Release reset and accept on the very first rising edge afterwards.
    task automatic test_mode0_unit();
        int lat;
        logic [31:0] e;
        rst_n = 1'b1;
        send(16'd1, 16'd1, 2'd0, lat);
        e = exp_q.pop_front();
        checks++; if (lat != 3) begin errors++; $display("FAIL unit_latency got=%0d exp=3", lat); end
        checks++; if (P !== 32'd1 || e !== 32'd1) begin errors++; $display("FAIL unit_P got=%h exp=%h", P, e); end
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL unit_ov_drop got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL unit_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_modes();
        int lat, explat;
        logic [31:0] e;
        logic [15:0] av[6] = '{16'h0000, 16'h1234, 16'hFFFF, 16'h8001, 16'h00FF, 16'h0100};
        logic [15:0] bv[6] = '{16'hFFFF, 16'h0000, 16'hFFFF, 16'h7F3C, 16'hABCD, 16'h0101};
        logic [1:0]  mv[6] = '{2'd1, 2'd3, 2'd0, 2'd3, 2'd1, 2'd0};
        for (int i = 0; i < 6; i++) begin
            send(av[i], bv[i], mv[i], lat);
            explat = (mv[i] == 2'd0) ? 3 : 4;
            checks++; if (lat != explat) begin errors++; $display("FAIL modes_latency[%0d] got=%0d exp=%0d", i, lat, explat); end
            e = exp_q.pop_front();
            checks++; if (P !== e) begin errors++; $display("FAIL modes_P[%0d] got=%h exp=%h", i, P, e); end
            if (i < 2) begin
                checks++; if (P !== 32'd0) begin errors++; $display("FAIL zero_operand_P[%0d] got=%h exp=0", i, P); end
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random_mode2();
        int lat;
        logic [31:0] e;
        logic [15:0] a, b;
        for (int i = 0; i < 1000; i++) begin
            a = 16'($urandom);
            b = 16'($urandom);
            if (i == 0) begin a = 16'hFFFF; b = 16'hFFFF; end
            if (i == 1) begin a = 16'h8000; b = 16'h0001; end
            if (i == 2) begin a = 16'h01FF; b = 16'h00FF; end
            send(a, b, 2'd2, lat);
            checks++; if (lat != 6) begin errors++; $display("FAIL rand_latency[%0d] got=%0d exp=6", i, lat); end
            e = exp_q.pop_front();
            checks++; if (P !== e) begin errors++; $display("FAIL rand_P[%0d] a=%h b=%h got=%h exp=%h", i, a, b, P, e); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        int lat, extra;
        logic [31:0] e;
        out_ready = 1'b0;
        send(16'hFFFF, 16'hFFFF, 2'd1, lat);
        e = exp_q.pop_front();
        checks++; if (lat != 4) begin errors++; $display("FAIL bp_latency got=%0d exp=4", lat); end
        checks++; if (P !== 32'hFEFF0100) begin errors++; $display("FAIL bp_P got=%h exp=FEFF0100", P); end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (P !== e || in_ready !== 1'b0 || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d] P=%h in_ready=%b out_valid=%b exp P=%h in_ready=0 out_valid=1", i, P, in_ready, out_valid, e);
            end
        end
        out_ready = 1'b1;
        @(negedge clk);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_release got=%b exp=0", out_valid); end
        extra = 0;
        repeat (5) begin @(negedge clk); if (out_valid) extra++; end
        checks++; if (extra != 0) begin errors++; $display("FAIL bp_single_result extra=%0d exp=0", extra); end
    endtask

    task automatic test_reset_mid_mul();
        int lat, stray;
        logic [31:0] e;
        A = 16'hBEEF; B = 16'h1357; mode = 2'd2; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy got=%b exp=1", busy); end
        repeat (2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0 || P !== 32'd0) begin
            errors++;
            $display("FAIL rst_mid_outputs out_valid=%b in_ready=%b busy=%b P=%h exp 0/1/0/0", out_valid, in_ready, busy, P);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        repeat (10) begin @(negedge clk); if (out_valid) stray++; end
        checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_stray_valid got=%0d exp=0", stray); end
        send(16'hCAFE, 16'h0F0F, 2'd2, lat);
        e = exp_q.pop_front();
        checks++; if (lat != 6) begin errors++; $display("FAIL rst_mid_next_latency got=%0d exp=6", lat); end
        checks++; if (P !== e) begin errors++; $display("FAIL rst_mid_next_P got=%h exp=%h", P, e); end
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        int cyc, last_acc, n_acc, n_res;
        logic [31:0] e;
        out_ready = 1'b1;
        mode = 2'd0; in_valid = 1'b1;
        A = 16'($urandom); B = 16'($urandom);
        last_acc = -1; n_acc = 0; n_res = 0;
        for (cyc = 0; cyc < 80; cyc++) begin
            if (cyc == 60) in_valid = 1'b0;
            if (out_valid) begin
                n_res++;
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL b2b_extra_result P=%h exp=none", P);
                end else begin
                    e = exp_q.pop_front();
                    checks++; if (P !== e) begin errors++; $display("FAIL b2b_P[%0d] got=%h exp=%h", n_res, P, e); end
                end
            end
            if (in_ready && in_valid) begin
                if (last_acc >= 0) begin
                    checks++; if (cyc - last_acc != 4) begin errors++; $display("FAIL b2b_gap got=%0d exp=4", cyc - last_acc); end
                end
                last_acc = cyc;
                exp_q.push_back(model(A, B, 2'd0));
                n_acc++;
                @(negedge clk);
                A = 16'($urandom); B = 16'($urandom);
            end else begin
                @(negedge clk);
            end
        end
        checks++; if (n_res != n_acc || exp_q.size() != 0) begin errors++; $display("FAIL b2b_count results=%0d accepts=%0d pending=%0d", n_res, n_acc, exp_q.size()); end
        checks++; if (n_acc != 15) begin errors++; $display("FAIL b2b_accepts got=%0d exp=15", n_acc); end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_mode0_unit();
        test_modes();
        test_random_mode2();
        test_backpressure();
        test_reset_mid_mul();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
